// File: rtl/encoder4to2_seq_pkg.sv
// encoder4to2_seq_pkg
// Shared definitions for the sequential 4-to-2 encoder: FSM state encoding
// and the width constants used by the top level and the priority selector.
// Configuration macro: ENC4TO2_MSB_FIRST_EN (affects prio_sel4 only).
package encoder4to2_seq_pkg;

  // Number of request lines and width of the binary code they map onto.
  localparam int ENC_N_IN  = 4;
  localparam int ENC_OUT_W = 2;

  // IDLE waits for a vector, EMIT walks the pending mask one code at a time.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } encState_e;

endpackage

// File: rtl/encoder4to2_seq_prio_sel4.sv
// prio_sel4
// Combinational 4-to-2 priority selector. Picks one set bit of the request
// mask and reports both its binary index and a one-hot mask of that bit.
// Configuration macro: ENC4TO2_MSB_FIRST_EN
//   undefined -> lowest set bit wins
//   defined   -> highest set bit wins
// Ports:
//   i_req   in   4  request mask
//   o_idx   out  2  index of the selected bit (0 when i_req is zero)
//   o_mask  out  4  one-hot mask of the selected bit (0 when i_req is zero)
module prio_sel4
  import encoder4to2_seq_pkg::*;
(
  input  logic [ENC_N_IN-1:0]  i_req,
  output logic [ENC_OUT_W-1:0] o_idx,
  output logic [ENC_N_IN-1:0]  o_mask
);

  // The scan direction is chosen so that the bit with the highest priority
  // is the last one written, which lets a plain loop act as a priority chain.
  always_comb begin
    o_idx  = '0;
    o_mask = '0;
`ifdef ENC4TO2_MSB_FIRST_EN
    for (int k = 0; k < ENC_N_IN; k++) begin
      if (i_req[k]) begin
        o_idx  = ENC_OUT_W'(k);
        o_mask = ENC_N_IN'(1) << k;
      end
    end
`else
    for (int k = ENC_N_IN - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_idx  = ENC_OUT_W'(k);
        o_mask = ENC_N_IN'(1) << k;
      end
    end
`endif
  end

endmodule

// File: rtl/encoder4to2_seq.sv
// encoder4to2_seq
// Sequential 4-to-2 encoder. A multi-hot request vector is captured in IDLE
// and then emitted as a stream of binary indices, one per accepted handshake,
// until every set bit has been reported exactly once. An all-zero vector is
// consumed and flagged with a one-cycle zero_err pulse.
// Configuration macro: ENC4TO2_MSB_FIRST_EN (descending emit order when set,
// ascending otherwise; handled inside prio_sel4).
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  request vector present
//   in_ready   out  1  vector accepted this cycle (IDLE)
//   in         in   4  request vector, multi-hot allowed
//   out_valid  out  1  code on out is valid
//   out_ready  in   1  consumer takes the code this cycle
//   out        out  2  index of the currently selected request bit
//   out_last   out  1  current code is the final one of the vector
//   zero_err   out  1  pulse: an all-zero vector was consumed
module encoder4to2_seq
  import encoder4to2_seq_pkg::*;
#(
  parameter int N_IN = ENC_N_IN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ENC_OUT_W-1:0] out,
  output logic                 out_last,
  output logic                 zero_err
);

  encState_e            r_state;
  logic [N_IN-1:0]      r_pend;
  logic                 r_outValid;
  logic [ENC_OUT_W-1:0] r_out;
  logic                 r_outLast;
  logic                 r_zeroErr;

  logic                 w_capture;
  logic                 w_take;
  logic [N_IN-1:0]      w_emitMask;
  logic [N_IN-1:0]      w_pendNext;
  logic [ENC_OUT_W-1:0] w_nextIdx;
  logic [N_IN-1:0]      w_nextMask;
  logic                 w_nextLast;

  // Handshake qualifiers: a non-zero vector arriving in IDLE starts a burst,
  // an accepted code in EMIT retires the bit currently shown on out.
  assign w_capture  = (r_state == IDLE) && in_valid && (in != '0);
  assign w_take     = (r_state == EMIT) && out_ready;
  assign w_emitMask = N_IN'(1) << r_out;

  // Pending mask as it will look after this edge. The outputs are registered,
  // so the selector looks ahead at this value rather than at r_pend.
  always_comb begin
    w_pendNext = r_pend;
    if (w_capture) begin
      w_pendNext = in;
    end else if (w_take) begin
      w_pendNext = r_pend & ~w_emitMask;
    end
  end

  prio_sel4 u_sel (
    .i_req  (w_pendNext),
    .o_idx  (w_nextIdx),
    .o_mask (w_nextMask)
  );

  // The next code is the last one exactly when the selected bit is the only
  // bit still pending.
  assign w_nextLast = (w_pendNext != '0) && (w_pendNext == w_nextMask);

  // Main FSM. Every output except in_ready is registered here so that out,
  // out_last and out_valid change only on clock edges and hold while the
  // consumer stalls. Reset discards any burst still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_outValid <= 1'b0;
      r_out      <= '0;
      r_outLast  <= 1'b0;
      r_zeroErr  <= 1'b0;
    end else begin
      r_pend    <= w_pendNext;
      r_zeroErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in != '0) begin
              r_state    <= EMIT;
              r_outValid <= 1'b1;
              r_out      <= w_nextIdx;
              r_outLast  <= w_nextLast;
            end else begin
              r_zeroErr <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_outLast) begin
              r_state    <= IDLE;
              r_outValid <= 1'b0;
              r_out      <= '0;
              r_outLast  <= 1'b0;
            end else begin
              r_out     <= w_nextIdx;
              r_outLast <= w_nextLast;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign out       = r_out;
  assign out_last  = r_outLast;
  assign zero_err  = r_zeroErr;

endmodule

// File: tb/tb_encoder4to2_seq.sv
// tb_encoder4to2_seq
// Bench for encoder4to2_seq. A queue-based reference model holds the codes
// still owed for the captured vector; expected outputs are read off that
// queue each cycle. Directed scenarios come first, then random traffic.
// Configuration macro: ENC4TO2_MSB_FIRST_EN (flips the model's emit order).
module tb_encoder4to2_seq;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [3:0] inVec;
  logic       outValid;
  logic       outReady;
  logic [1:0] outCode;
  logic       outLast;
  logic       zeroErr;

  int total = 0;
  int bad   = 0;

  int  expQ[$];
  bit  expZero = 1'b0;

  encoder4to2_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in        (inVec),
    .out_valid (outValid),
    .out_ready (outReady),
    .out       (outCode),
    .out_last  (outLast),
    .zero_err  (zeroErr)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the model queue: anything queued
  // means a code is on offer, the head is that code, one left means last.
  task automatic checkOutput(input string step);
    logic [3:0] eCode;
    eCode = (expQ.size() > 0) ? 4'(expQ[0]) : 4'd0;
    checkOne({step, ".in_ready"},  {3'b0, inReady},  {3'b0, expQ.size() == 0});
    checkOne({step, ".out_valid"}, {3'b0, outValid}, {3'b0, expQ.size() > 0});
    checkOne({step, ".out"},       {2'b0, outCode},  eCode);
    checkOne({step, ".out_last"},  {3'b0, outLast},  {3'b0, expQ.size() == 1});
    checkOne({step, ".zero_err"},  {3'b0, zeroErr},  {3'b0, expZero});
  endtask

  // One clock cycle: check outputs away from the edge, drive the inputs,
  // then advance the model with exactly what the DUT saw at the edge.
  task automatic applyStimulus(input string step, input logic r, input logic v,
                               input logic [3:0] vec, input logic rdy);
    @(negedge clk);
    checkOutput(step);
    rst      = r;
    inValid  = v;
    inVec    = vec;
    outReady = rdy;
    @(posedge clk);
    if (r) begin
      expQ.delete();
      expZero = 1'b0;
    end else begin
      expZero = 1'b0;
      if (expQ.size() == 0) begin
        if (v) begin
          if (vec == 4'd0) begin
            expZero = 1'b1;
          end else begin
`ifdef ENC4TO2_MSB_FIRST_EN
            for (int b = 3; b >= 0; b--) if (vec[b]) expQ.push_back(b);
`else
            for (int b = 0; b < 4; b++) if (vec[b]) expQ.push_back(b);
`endif
          end
        end
      end else if (rdy) begin
        void'(expQ.pop_front());
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inVec    = 4'd0;
    outReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    expQ.delete();
    expZero = 1'b0;

    // Reset values
    applyStimulus("reset", 1'b0, 1'b0, 4'd0, 1'b0);

    // Single request bit
    applyStimulus("single", 1'b0, 1'b1, 4'b0100, 1'b1);
    applyStimulus("single", 1'b0, 1'b0, 4'b0000, 1'b1);
    applyStimulus("single", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Multi-hot vector, streamed at full rate
    applyStimulus("multi", 1'b0, 1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("multi", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Backpressure holds the current code
    applyStimulus("bp", 1'b0, 1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("bp", 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("bp", 1'b0, 1'b0, 4'b0000, 1'b1);

    // All-zero vector
    applyStimulus("zero", 1'b0, 1'b1, 4'b0000, 1'b1);
    applyStimulus("zero", 1'b0, 1'b0, 4'b0000, 1'b1);
    applyStimulus("zero", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Back-to-back zero vectors, then a capture right after the pulse
    applyStimulus("zero2", 1'b0, 1'b1, 4'b0000, 1'b0);
    applyStimulus("zero2", 1'b0, 1'b1, 4'b1000, 1'b0);
    applyStimulus("zero2", 1'b0, 1'b0, 4'b0000, 1'b1);
    applyStimulus("zero2", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Reset in the middle of a burst
    applyStimulus("midrst", 1'b0, 1'b1, 4'b1111, 1'b1);
    applyStimulus("midrst", 1'b0, 1'b0, 4'b0000, 1'b1);
    applyStimulus("midrst", 1'b1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("midrst", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic       v;
      logic [3:0] vec;
      logic       rdy;
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 1) == 1);
      vec = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 9) < 7);
      applyStimulus("rand", r, v, vec, rdy);
    end

    // Drain and final check
    for (int i = 0; i < 6; i++) applyStimulus("drain", 1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder4to2_seq.md
ENCODER4TO2_SEQ -- requirements
Module: encoder4to2_seq

Interface
REQ-001 The block SHALL have one parameter: N_IN, default 4, number of request lines (only 4 supported; OUT_W = 2 derived).
REQ-002 The block SHALL have the ports:
- clk        input   1  rising-edge clock.
- rst        input   1  synchronous, active-high reset.
- in_valid   input   1  input vector present.
- in_ready   output  1  block accepts a vector this cycle.
- in         input   4  request vector, multi-hot allowed.
- out_valid  output  1  code on out is valid.
- out_ready  input   1  consumer takes code this cycle.
- out        output  2  binary index of one set request bit.
- out_last   output  1  current code is the final one for the captured vector.
- zero_err   output  1  one-cycle pulse: all-zero vector consumed.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, on ports clk and rst.

Function
REQ-004 The block SHALL implement a two-state FSM, IDLE and EMIT, with a 4-bit pending-mask register pend.
REQ-005 In IDLE: in_ready=1, out_valid=0.
REQ-006 In IDLE, if in_valid=1 and in!=0, the block SHALL load pend<=in and enter EMIT on the same edge.
REQ-007 In IDLE, if in_valid=1 and in==0, the block SHALL consume the vector, stay in IDLE, and assert zero_err for exactly the next cycle.
REQ-008 In EMIT: in_ready=0, out_valid=1, out = index of the lowest set bit of pend.
REQ-009 In EMIT: out_last=1 iff pend has exactly one bit set; otherwise out_last=0.
REQ-010 In EMIT, on out_ready=1 the block SHALL clear the emitted bit of pend; if out_last=1 it SHALL return to IDLE on the same edge.
REQ-011 If out_ready=0 in EMIT, out, out_last and pend SHALL hold unchanged.
REQ-012 Latency: out_valid SHALL rise the cycle after capture; throughput SHALL be one code per cycle while out_ready=1.
REQ-013 The block SHALL take a new vector at the earliest one cycle after the last code is taken (IDLE cycle); vectors presented during EMIT SHALL be ignored (in_ready=0).
REQ-014 When out_valid=0, out and out_last SHALL be 0.
REQ-015 A vector with k set bits SHALL produce exactly k codes, each index exactly once, in ascending order.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL enter IDLE, pend<=0 and zero_err<=0; rst SHALL take priority over all other inputs, including mid-EMIT (pending codes discarded).
REQ-017 Values after reset: in_ready=1, out_valid=0, out=0, out_last=0, zero_err=0.

Configuration
REQ-018 The macro ENC4TO2_MSB_FIRST_EN SHALL select the emit order.
REQ-019 With ENC4TO2_MSB_FIRST_EN defined, out SHALL be the highest set bit of pend and codes SHALL be emitted in descending order.
REQ-020 Without ENC4TO2_MSB_FIRST_EN, the behaviour SHALL be as in REQ-008 (lowest bit first, ascending order).

Structure
REQ-021 State encodings (IDLE=1'b0, EMIT=1'b1) and the width constants (N_IN=4, OUT_W=2) SHALL live in the shared header encoder_defs.vh.
REQ-022 The combinational 4-to-2 priority selector (pend -> index, one-hot mask of the selected bit) SHALL be a sub-module, prio_sel4.
REQ-023 prio_sel4 SHALL also honour ENC4TO2_MSB_FIRST_EN.

Verification
REQ-024 Single bit: in=4'b0100, in_valid=1, out_ready=1 -> next cycle out=2'b10, out_last=1, out_valid=1; then IDLE.
REQ-025 Multi-hot (default order): in=4'b1011, out_ready=1 -> out=00,01,11 on three consecutive cycles; out_last=1 only on 11.
REQ-026 Backpressure: in=4'b0110, out_ready=0 for 3 cycles -> out=01 held, out_last=0; then out_ready=1 -> 01, then 10 with out_last=1.
REQ-027 Zero input: in=4'b0000, in_valid=1 in IDLE -> zero_err=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-028 Reset mid-operation: in=4'b1111, rst=1 after the first code -> next cycle out_valid=0, in_ready=1; the remaining codes are never emitted.
REQ-029 With ENC4TO2_MSB_FIRST_EN defined: in=4'b1011 -> out=11,01,00; out_last=1 on 00.
